// File: rtl/exibe_sequencia.sv
// Memory-game playback: walks ROM addresses 0..limite, lights each stored pattern
// for T_ACESO cycles, blanks the LEDs for T_APAGADO cycles, then pulses pronto.
module exibe_sequencia #(
    parameter int T_ACESO   = 1000,
    parameter int T_APAGADO = 250
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] rom_dado,
    output logic [3:0] rom_end,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [2:0] db_estado
);

    localparam int T_MAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
    localparam int TW    = (T_MAX < 2) ? 1 : $clog2(T_MAX);

    localparam logic [TW-1:0] FIM_ACESO   = TW'(T_ACESO - 1);
    localparam logic [TW-1:0] FIM_APAGADO = TW'(T_APAGADO - 1);
    localparam logic [TW-1:0] TIMER_SAT   = TW'(T_MAX - 1);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ACESO   = 3'd2,
        APAGADO = 3'd3,
        FIM     = 3'd4
    } estado_t;

    estado_t       r_estado;
    logic [3:0]    r_end;
    logic [3:0]    r_lim;
    logic [TW-1:0] r_timer;

    // Timer never wraps: it parks at its largest useful count.
    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (v == TIMER_SAT) ? v : v + TW'(1);
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= OCIOSO;
            r_end    <= '0;
            r_lim    <= '0;
            r_timer  <= '0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (iniciar) begin
                        r_lim    <= limite;
                        r_end    <= '0;
                        r_estado <= CARREGA;
                    end
                end
                CARREGA: begin
                    r_timer  <= '0;
                    r_estado <= ACESO;
                end
                ACESO: begin
                    if (r_timer == FIM_ACESO) begin
                        r_timer  <= '0;
                        r_estado <= APAGADO;
                    end else begin
                        r_timer <= sat_inc(r_timer);
                    end
                end
                APAGADO: begin
                    if (r_timer == FIM_APAGADO) begin
                        r_timer <= '0;
                        // Stop on the last index instead of incrementing, so no wrap.
                        if (r_end == r_lim) begin
                            r_estado <= FIM;
                        end else begin
                            r_end    <= r_end + 4'd1;
                            r_estado <= CARREGA;
                        end
                    end else begin
                        r_timer <= sat_inc(r_timer);
                    end
                end
                FIM:     r_estado <= OCIOSO;
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    // Outputs decode registered state only; ROM data is already registered upstream.
    assign rom_end   = r_end;
    assign leds      = (r_estado == ACESO) ? rom_dado : 4'd0;
    assign ocupado   = (r_estado != OCIOSO);
    assign pronto    = (r_estado == FIM);
    assign db_estado = r_estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Bench for exibe_sequencia: sync ROM model plus a per-cycle reference computed
// from the playback timeline (pattern index and phase from elapsed cycles).
module tb_exibe_sequencia;

    localparam int TA  = 4;
    localparam int TP  = 2;
    localparam int PER = 1 + TA + TP;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       iniciar;
    logic [3:0] limite;
    logic [3:0] rom_dado = 4'd0;
    logic [3:0] rom_end;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [2:0] db_estado;

    logic [3:0] rom_mem [16];

    int n_chk  = 0;
    int n_pass = 0;

    exibe_sequencia #(.T_ACESO(TA), .T_APAGADO(TP)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .iniciar  (iniciar),
        .limite   (limite),
        .rom_dado (rom_dado),
        .rom_end  (rom_end),
        .leds     (leds),
        .ocupado  (ocupado),
        .pronto   (pronto),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // 16x4 synchronous ROM, one cycle of read latency
    always @(posedge clock) rom_dado <= rom_mem[rom_end];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (time %0t)", tag, obs, expv, $time);
    endtask

    // One playback started by iniciar at edge k; t counts edges after k.
    // Pattern p occupies t in [p*PER, (p+1)*PER): 1 fetch cycle, TA lit, TP dark.
    // After the last pattern comes one FIM cycle, then idle.
    task automatic run_play(input int lim, input bit meddle, input bit hold);
        int n;
        int p;
        int r;
        logic [3:0] e_end, e_led;
        logic       e_busy, e_pr;
        logic [2:0] e_st;
        n = (lim + 1) * PER;
        @(negedge clock);
        iniciar = 1'b1;
        limite  = lim[3:0];
        for (int t = 0; t <= n + 1; t++) begin
            @(posedge clock);
            #1;
            if (t < n) begin
                p      = t / PER;
                r      = t % PER;
                e_end  = p[3:0];
                e_led  = (r >= 1 && r <= TA) ? rom_mem[p] : 4'd0;
                e_busy = 1'b1;
                e_pr   = 1'b0;
                e_st   = (r == 0) ? 3'd1 : ((r <= TA) ? 3'd2 : 3'd3);
            end else if (t == n) begin
                e_end = lim[3:0]; e_led = 4'd0; e_busy = 1'b1; e_pr = 1'b1; e_st = 3'd4;
            end else begin
                e_end = lim[3:0]; e_led = 4'd0; e_busy = 1'b0; e_pr = 1'b0; e_st = 3'd0;
            end
            chk("rom_end", rom_end, e_end);
            chk("leds", leds, e_led);
            chk("ocupado", ocupado, e_busy);
            chk("pronto", pronto, e_pr);
            chk("db_estado", db_estado, e_st);
            if (t <= n) begin
                @(negedge clock);
                if (t < n && meddle) begin
                    iniciar = 1'($urandom_range(0, 1));
                    limite  = 4'($urandom_range(0, 15));
                end else begin
                    iniciar = hold;
                    limite  = lim[3:0];
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        iniciar = 1'b0;
        limite  = 4'd0;
        for (int i = 0; i < 16; i++) rom_mem[i] = 4'(1 << (i % 4));
        repeat (3) @(posedge clock);
        #1;
        chk("rst_rom_end", rom_end, 4'd0);
        chk("rst_leds", leds, 4'd0);
        chk("rst_ocupado", ocupado, 1'b0);
        chk("rst_pronto", pronto, 1'b0);
        chk("rst_estado", db_estado, 3'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);

        // Reference patterns 1,2,4,8,...
        run_play(0, 1'b0, 1'b0);
        run_play(3, 1'b0, 1'b0);
        run_play(15, 1'b0, 1'b0);
        run_play(3, 1'b1, 1'b0);

        // Random non-zero ROM contents, random lengths, random interference
        for (int i = 0; i < 16; i++) rom_mem[i] = 4'($urandom_range(1, 15));
        for (int i = 0; i < 4; i++) run_play(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);

        // Asynchronous reset in the middle of the second lit pattern
        @(negedge clock);
        iniciar = 1'b1;
        limite  = 4'd3;
        @(posedge clock);
        @(negedge clock);
        iniciar = 1'b0;
        repeat (PER + 2) @(posedge clock);
        #1;
        chk("pre_rst_leds", leds, rom_mem[1]);
        chk("pre_rst_rom_end", rom_end, 4'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_leds", leds, 4'd0);
        chk("async_rom_end", rom_end, 4'd0);
        chk("async_ocupado", ocupado, 1'b0);
        chk("async_pronto", pronto, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            chk("rst_hold_pronto", pronto, 1'b0);
            chk("rst_hold_ocupado", ocupado, 1'b0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        run_play(2, 1'b0, 1'b0);

        // iniciar held high: back-to-back playbacks with one idle cycle between
        run_play(1, 1'b0, 1'b1);
        run_play(1, 1'b0, 1'b1);
        run_play(1, 1'b0, 1'b0);

        repeat (3) @(posedge clock);
        #1;
        chk("final_idle", ocupado, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
